// File: rtl/definesPkg.sv
// Shared APB definitions: bus widths, default wait-state timeout and the
// master-side phase encoding.
package definesPkg;
    localparam int APB_ADDR_WIDTH      = 32;
    localparam int APB_DATA_WIDTH      = 32;
    localparam int APB_DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: a rotating priority pointer selects the first active
// request at or after ptr; the pointer moves past the winner on advance.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;
    logic          found;
    int            sum;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        sum   = 0;
        for (int k = 0; k < N; k++) begin
            sum = int'(ptr_q) + k;
            if (sum >= N) sum = sum - N;
            cand = IW'(sum);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found)
            ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end
endmodule

// File: rtl/apb_rr_master.sv
// APB3 master shared by NUM_REQ requesters: round-robin grant, SETUP/ACCESS
// sequencing with PREADY wait states, optional timeout, one-cycle responses.
module apb_rr_master
    import definesPkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = APB_ADDR_WIDTH,
    parameter int DATA_W  = APB_DATA_WIDTH,
    parameter int TIMEOUT = APB_DEFAULT_TIMEOUT
) (
    input  logic                      apbClk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY
);
    localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e          state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic                psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                timeout_hit, xfer_done, accept, advance;
    logic [NUM_REQ-1:0]  gnt;
    logic [IW-1:0]       gidx;

    assign timeout_hit = (TIMEOUT != 0) && (state_q == APB_ACCESS) && !PREADY
                         && (wcnt_q == WCNT_W'(TIMEOUT - 1));
    assign xfer_done   = (state_q == APB_ACCESS) && (PREADY || timeout_hit);
    // Grants happen only when the bus is free or frees up on this edge.
    assign accept      = (state_q == APB_IDLE) || xfer_done;
    assign advance     = accept && (|req_valid);
    assign req_ready   = accept ? gnt : '0;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk_i     (apbClk),
        .rst_ni    (rst),
        .req_i     (req_valid),
        .advance_i (advance),
        .gnt_o     (gnt),
        .idx_o     (gidx)
    );

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        owner_d     = owner_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            APB_IDLE:  state_d = APB_IDLE;
            APB_SETUP: state_d = APB_ACCESS;
            APB_ACCESS: begin
                if (xfer_done) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = pwrite_q ? '0 : PRDATA;
                    rsp_err_d            = timeout_hit;
                    state_d              = APB_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = APB_IDLE;
        endcase

        if (advance) begin
            state_d  = APB_SETUP;
            wcnt_d   = '0;
            owner_d  = gidx;
            pwrite_d = req_write[gidx];
            paddr_d  = req_addr[gidx*ADDR_W +: ADDR_W];
            pwdata_d = req_wdata[gidx*DATA_W +: DATA_W];
        end

        // Bus controls are registered from the next state to stay glitch-free.
        psel_d    = (state_d != APB_IDLE);
        penable_d = (state_d == APB_ACCESS);
    end

    always_ff @(posedge apbClk or negedge rst) begin
        if (!rst) begin
            state_q     <= APB_IDLE;
            wcnt_q      <= '0;
            owner_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            owner_q     <= owner_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: doc/apb_rr_master.md
# apb_rr_master

Round-robin APB master controller that shares a single APB3 master port among `NUM_REQ` independent requesters. It:
- arbitrates pending requests;
- sequences the SETUP and ACCESS phases;
- honours `PREADY` wait states, with an optional timeout;
- returns read data and a completion strobe to the winning requester.

It sits between on-chip agents (DMA, CPU bridge, test sequencer) and the APB fabric, in place of a single-owner bus driver.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..16)
- `ADDR_W`, `APB_ADDR_WIDTH`, address width
- `DATA_W`, `APB_DATA_WIDTH`, data width
- `TIMEOUT`, 16, maximum ACCESS cycles without `PREADY` before abort; 0 disables the timeout

Ports (one clock; reset is asynchronous and active-low):
- `apbClk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous active-low reset
- `req_valid`  in  `NUM_REQ`  request pending, one bit per requester
- `req_write`  in  `NUM_REQ`  1 = write, 0 = read
- `req_addr`  in  `NUM_REQ*ADDR_W`  packed addresses, requester i at `[i*ADDR_W +: ADDR_W]`
- `req_wdata`  in  `NUM_REQ*DATA_W`  packed write data
- `req_ready`  out  `NUM_REQ`  one-hot accept strobe (combinational)
- `rsp_valid`  out  `NUM_REQ`  one-hot completion pulse, 1 cycle
- `rsp_rdata`  out  `DATA_W`  read data, valid with `rsp_valid`
- `rsp_err`  out  1  timeout abort flag, valid with `rsp_valid`
- `PSEL`, `PENABLE`, `PWRITE`  out  1  APB control
- `PADDR`  out  `ADDR_W`  APB address
- `PWDATA`  out  `DATA_W`  APB write data
- `PRDATA`  in  `DATA_W`  APB read data
- `PREADY`  in  1  APB slave ready

## Operation
States:
- **IDLE**: `PSEL`=0, `PENABLE`=0.
- **SETUP**: `PSEL`=1, `PENABLE`=0, always exactly one cycle.
- **ACCESS**: `PSEL`=1, `PENABLE`=1, held until `PREADY`=1 or timeout.

Accept points:
- A request is accepted only in IDLE, or in the ACCESS cycle that completes (`PREADY`=1 or timeout).
- `req_ready[g]`=1 for the arbitration winner g in that cycle; all other bits are 0.
- On acceptance: latch `PADDR`/`PWRITE`/`PWDATA` from requester g, next state = SETUP.
- With no request pending, the next state is IDLE.

Round-robin:
- Priority pointer `ptr` (reset 0) gives first priority to requester `ptr`, then `ptr+1`, and so on, modulo `NUM_REQ`.
- On each grant, `ptr` becomes g+1 mod `NUM_REQ`.
- Fairness: no requester waits more than `NUM_REQ`-1 other grants.

Requester contract:
- The requester holds its address, write and data fields stable while `req_valid`=1 and `req_ready`=0.
- `req_valid` deasserting before acceptance withdraws the request with no side effects.

Completion:
- Registered outputs: `rsp_valid[g]`=1 for one cycle.
- `rsp_rdata` is `PRDATA` sampled at the completing edge for reads, and 0 for writes.
- `rsp_err` = (completion was a timeout).

Timeout:
- An ACCESS-cycle counter `wcnt` (width `$clog2(TIMEOUT+1)`) is cleared on entering SETUP.
- The counter increments on each ACCESS cycle with `PREADY`=0.
- When `wcnt`==`TIMEOUT`-1 and `PREADY`=0, the transfer is forced complete with `rsp_err`=1.
- `PSEL` and `PENABLE` drop, or SETUP starts for the next grant.

Reset:
- All outputs are 0, `ptr`=0, state IDLE.
- Reset asserted mid-transfer aborts immediately; no `rsp_valid` is produced for the aborted transfer.

## Timing
- Best-case latency: accept edge E0 → SETUP after E0 → ACCESS after E1 → `PREADY`=1 at E2 → `rsp_valid` high in the cycle after E2.
- Result: 3 cycles from accept to response, plus any wait states.
- Back-to-back transfers: `PSEL` stays 1, and `PENABLE` returns to 0 for the new SETUP with the new `PADDR`. Throughput is one transfer per 2 cycles.
- The winner's `rsp_valid` and a new grant's SETUP appear in the same cycle.
- `req_ready` depends combinationally on `req_valid`, state, `PREADY`, `ptr` and `wcnt`. All APB outputs and `rsp_*` are registered.

## Structure
- The shared package `definesPkg` owns the following; all other logic stays local:
  - `APB_ADDR_WIDTH` and `APB_DATA_WIDTH`;
  - a new `typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e`;
  - `APB_DEFAULT_TIMEOUT`.
- Sub-module `rr_arbiter #(N)`:
  - inputs: request vector, `ptr`, an `advance` strobe;
  - outputs: one-hot grant and the grant index;
  - owns the `ptr` register, async reset.
- The top level contains the FSM, the transfer latches, `wcnt`, and the response registers.

## Test plan
1. **Single write**: requester 0 writes 0xDEAD_BEEF to 0x10, `PREADY` tied 1.
   - Expect the SETUP/ACCESS pattern on cycles 1–2 with `PWRITE`=1.
   - Expect `rsp_valid[0]` on cycle 3 with `rsp_err`=0.
2. **Read with wait states**: requester 2 reads 0x20; slave holds `PREADY`=0 for 3 ACCESS cycles, then returns 0x1234_5678.
   - Expect ACCESS to last 4 cycles, `PADDR` stable throughout, then `rsp_rdata`=0x1234_5678 on `rsp_valid[2]`.
3. **All requesters continuously valid** with `NUM_REQ`=4.
   - Expect grant order 0,1,2,3,0,1…, back-to-back with no IDLE cycle and `PSEL` never dropping.
4. **Timeout**: `TIMEOUT`=16 and `PREADY` stuck at 0.
   - Expect ACCESS for exactly 16 cycles, then `rsp_valid` with `rsp_err`=1, and the bus returns to IDLE.
5. **Reset mid-ACCESS**: assert `rst`=0 during ACCESS.
   - Expect `PSEL`/`PENABLE`=0 asynchronously and no `rsp_valid`.
   - After release, requester 0 has first priority.
6. **Withdrawal**: requester 1 withdraws `req_valid` while requester 3 is in transfer.
   - Expect requester 1 never granted and requester 3 unaffected.
